// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage of the mini crypto processor. Owns the program
// counter and fetches 16-bit instruction words from instruction memory over
// a req/ack handshake. Each word is latched into the instruction register (IR)
// and its fields are presented to the control unit. The PC only moves when
// the control unit pulses pc_enable, and halt stops the unit until reset.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset (0 = in reset)
//   pc_enable    in   advance PC and fetch the next instruction (HOLD only)
//   halt         in   stop fetching, sticky until reset (HOLD only)
//   jump_en      in   with pc_enable, load jump_target instead of PC+1
//   jump_target  in   branch/jump destination
//   imem_req     out  instruction memory read request
//   imem_addr    out  read address, always the PC register
//   imem_ack     in   memory response valid, imem_rdata valid same cycle
//   imem_rdata   in   instruction word
//   opcode       out  IR[15:12]
//   rd, rs, rt   out  IR[11:8], IR[7:4], IR[3:0]
//   instr_valid  out  IR holds the instruction for the current PC
//   fetch_state  out  FSM state: IDLE=00, FETCH=01, HOLD=10, STOP=11
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pc_enable,
    input  logic                   halt,
    input  logic                   jump_en,
    input  logic [PC_WIDTH-1:0]    jump_target,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [3:0]             opcode,
    output logic [3:0]             rd,
    output logic [3:0]             rs,
    output logic [3:0]             rt,
    output logic                   instr_valid,
    output logic [1:0]             fetch_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        STOP  = 2'b11
    } state_t;

    state_t                 state;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] ir;

    // Fetch sequencer. imem_req and instr_valid are registered alongside the
    // state so every output comes straight from a flop; because the reset is
    // asynchronous, asserting it mid-fetch drops imem_req immediately.
    // PC arithmetic wraps naturally at 2^PC_WIDTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        ir          <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // halt wins over a simultaneous pc_enable and leaves PC alone
                    if (halt) begin
                        instr_valid <= 1'b0;
                        state       <= STOP;
                    end else if (pc_enable) begin
                        pc          <= jump_en ? jump_target : pc + PC_WIDTH'(1);
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                STOP: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign imem_addr   = pc;
    assign opcode      = ir[15:12];
    assign rd          = ir[11:8];
    assign rs          = ir[7:4];
    assign rt          = ir[3:0];
    assign fetch_state = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed testbench for instr_fetch_unit. Each scenario task drives its own
// stimulus and checks outputs against hand-computed values. Inputs change
// and outputs are sampled 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        pc_enable;
    logic        halt;
    logic        jump_en;
    logic [7:0]  jump_target;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic        instr_valid;
    logic [1:0]  fetch_state;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(
        .PC_WIDTH    (8),
        .INSTR_WIDTH (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_enable   (pc_enable),
        .halt        (halt),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .opcode      (opcode),
        .rd          (rd),
        .rs          (rs),
        .rt          (rt),
        .instr_valid (instr_valid),
        .fetch_state (fetch_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs can be sampled safely.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put the DUT back into reset and release it just after an edge, leaving
    // it in IDLE with the next edge being E0.
    task automatic do_reset();
        reset       = 1'b0;
        pc_enable   = 1'b0;
        halt        = 1'b0;
        jump_en     = 1'b0;
        jump_target = 8'h00;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        tick();
        reset = 1'b1;
    endtask

    // One-cycle ack with the given word (DUT must be in FETCH).
    task automatic fetch_word(input logic [15:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_ack   = ~imem_ack;
            pc_enable  = ~pc_enable;
            imem_rdata = 16'hFFFF;
            tick();
        end
        checks++;
        if ({imem_req, imem_addr, opcode, rd, rs, rt, instr_valid, fetch_state} !== 28'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got req=%b addr=%h op=%h rd=%h rs=%h rt=%h valid=%b state=%b, expected all zero",
                     imem_req, imem_addr, opcode, rd, rs, rt, instr_valid, fetch_state);
        end
        imem_ack  = 1'b0;
        pc_enable = 1'b0;
        reset     = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || fetch_state !== 2'b01 || imem_addr !== 8'h00) begin
            errors++;
            $display("[TB] FAIL e0_fetch: got req=%b state=%b addr=%h, expected req=1 state=01 addr=00",
                     imem_req, fetch_state, imem_addr);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || fetch_state !== 2'b00) begin
            errors++;
            $display("[TB] FAIL async_reset: got req=%b state=%b, expected req=0 state=00",
                     imem_req, fetch_state);
        end
        reset = 1'b1;
    endtask

    task automatic test_single_fetch();
        do_reset();
        imem_ack   = 1'b1;
        imem_rdata = 16'h1A53;
        tick();
        tick();
        imem_ack = 1'b0;
        checks++;
        if ({opcode, rd, rs, rt} !== 16'h1A53 || instr_valid !== 1'b1 || fetch_state !== 2'b10 || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fetch_lat0: got op=%h rd=%h rs=%h rt=%h valid=%b state=%b req=%b, expected 1A53 valid=1 state=10 req=0",
                     opcode, rd, rs, rt, instr_valid, fetch_state, imem_req);
        end

        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b0 || imem_req !== 1'b1 || fetch_state !== 2'b01) begin
                errors++;
                $display("[TB] FAIL fetch_wait%0d: got valid=%b req=%b state=%b, expected valid=0 req=1 state=01",
                         i, instr_valid, imem_req, fetch_state);
            end
        end
        fetch_word(16'h1A53);
        checks++;
        if ({opcode, rd, rs, rt} !== 16'h1A53 || instr_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fetch_lat3: got op=%h rd=%h rs=%h rt=%h valid=%b, expected 1A53 valid=1",
                     opcode, rd, rs, rt, instr_valid);
        end
    endtask

    task automatic test_sequential();
        logic [15:0] words [3];
        logic [3:0]  prev_op;
        words[0] = 16'h1000;
        words[1] = 16'h3000;
        words[2] = 16'h2000;
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_addr !== 8'(i) || imem_req !== 1'b1) begin
                errors++;
                $display("[TB] FAIL seq_addr%0d: got addr=%h req=%b, expected addr=%h req=1",
                         i, imem_addr, imem_req, 8'(i));
            end
            fetch_word(words[i]);
            prev_op = words[i][15:12];
            checks++;
            if (opcode !== prev_op || instr_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL seq_op%0d: got op=%h valid=%b, expected op=%h valid=1",
                         i, opcode, instr_valid, prev_op);
            end
            pc_enable = 1'b1;
            tick();
            pc_enable = 1'b0;
            checks++;
            if (instr_valid !== 1'b0 || opcode !== prev_op || imem_addr !== 8'(i + 1)) begin
                errors++;
                $display("[TB] FAIL seq_gap%0d: got valid=%b op=%h addr=%h, expected valid=0 op=%h addr=%h",
                         i, instr_valid, opcode, imem_addr, prev_op, 8'(i + 1));
            end
        end
    endtask

    task automatic test_wrap_jump();
        do_reset();
        tick();
        fetch_word(16'h5000);
        jump_en     = 1'b1;
        jump_target = 8'hFF;
        pc_enable   = 1'b1;
        tick();
        pc_enable = 1'b0;
        jump_en   = 1'b0;
        checks++;
        if (imem_addr !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL jump_ff: got addr=%h, expected addr=ff", imem_addr);
        end
        fetch_word(16'h6000);
        pc_enable = 1'b1;
        tick();
        pc_enable = 1'b0;
        checks++;
        if (imem_addr !== 8'h00 || fetch_state !== 2'b01) begin
            errors++;
            $display("[TB] FAIL wrap: got addr=%h state=%b, expected addr=00 state=01",
                     imem_addr, fetch_state);
        end
        fetch_word(16'h7000);
        jump_en     = 1'b1;
        jump_target = 8'h40;
        pc_enable   = 1'b1;
        tick();
        pc_enable = 1'b0;
        jump_en   = 1'b0;
        checks++;
        if (imem_addr !== 8'h40) begin
            errors++;
            $display("[TB] FAIL jump_40: got addr=%h, expected addr=40", imem_addr);
        end
        fetch_word(16'h8000);
        jump_en     = 1'b1;
        jump_target = 8'h99;
        tick();
        tick();
        jump_en = 1'b0;
        checks++;
        if (imem_addr !== 8'h40 || fetch_state !== 2'b10 || instr_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL jump_no_enable: got addr=%h state=%b valid=%b, expected addr=40 state=10 valid=1",
                     imem_addr, fetch_state, instr_valid);
        end
    endtask

    task automatic test_halt();
        do_reset();
        tick();
        fetch_word(16'hF000);
        halt      = 1'b1;
        pc_enable = 1'b1;
        tick();
        halt      = 1'b0;
        pc_enable = 1'b0;
        checks++;
        if (fetch_state !== 2'b11 || imem_addr !== 8'h00 || opcode !== 4'hF || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL halt_prio: got state=%b addr=%h op=%h valid=%b req=%b, expected state=11 addr=00 op=f valid=0 req=0",
                     fetch_state, imem_addr, opcode, instr_valid, imem_req);
        end
        pc_enable  = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'h1234;
        for (int i = 0; i < 3; i++) tick();
        pc_enable = 1'b0;
        imem_ack  = 1'b0;
        checks++;
        if (fetch_state !== 2'b11 || imem_addr !== 8'h00 || {opcode, rd, rs, rt} !== 16'hF000 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL halt_sticky: got state=%b addr=%h ir=%h%h%h%h valid=%b req=%b, expected state=11 addr=00 ir=f000 valid=0 req=0",
                     fetch_state, imem_addr, opcode, rd, rs, rt, instr_valid, imem_req);
        end
    endtask

    task automatic test_stray_ack();
        do_reset();
        tick();
        fetch_word(16'h1A53);
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        tick();
        tick();
        imem_ack = 1'b0;
        checks++;
        if ({opcode, rd, rs, rt} !== 16'h1A53 || fetch_state !== 2'b10 || instr_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stray_ack: got ir=%h%h%h%h state=%b valid=%b, expected ir=1a53 state=10 valid=1",
                     opcode, rd, rs, rt, fetch_state, instr_valid);
        end
    endtask

    initial begin
        reset       = 1'b0;
        pc_enable   = 1'b0;
        halt        = 1'b0;
        jump_en     = 1'b0;
        jump_target = 8'h00;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        test_reset();
        test_single_fetch();
        test_sequential();
        test_wrap_jump();
        test_halt();
        test_stray_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the mini crypto processor, directly upstream of `control_unit`. It owns the program counter and fetches 16-bit instruction words from instruction memory over a req/ack handshake. It latches each word into an instruction register and presents the decoded `opcode` and operand fields to the control unit. The PC advances only when the control unit pulses `pc_enable`, and the unit stops permanently on `halt`.

## Interface
- `PC_WIDTH`, default 8: program counter and instruction address width.
- `INSTR_WIDTH`, default 16: instruction word width. Field layout is fixed for 16: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 = reset asserted.
- `pc_enable`  in  1  from control_unit; advance the PC and fetch the next instruction.
- `halt`  in  1  from control_unit; stop fetching (sticky until reset).
- `jump_en`  in  1  qualifies `pc_enable`; load `jump_target` instead of PC+1.
- `jump_target`  in  PC_WIDTH  branch/jump destination.
- `imem_req`  out  1  instruction memory read request.
- `imem_addr`  out  PC_WIDTH  read address; always equals the PC register.
- `imem_ack`  in  1  memory response valid; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  INSTR_WIDTH  instruction word.
- `opcode`  out  4  IR[15:12], to control_unit.
- `rd`, `rs`, `rt`  out  4 each  IR[11:8], IR[7:4], IR[3:0].
- `instr_valid`  out  1  IR holds the instruction for the current PC.
- `fetch_state`  out  2  FSM state for debug: IDLE=00, FETCH=01, HOLD=10, STOP=11.

## Operation
- **Registers:** PC, IR, and the FSM state. All outputs are registered or are direct fields of registers.
- **IDLE:** entered only from reset. Unconditionally goes to FETCH on the next edge.
- **FETCH:**
  - `imem_req`=1.
  - On an edge with `imem_ack`=1: IR <= `imem_rdata`, `instr_valid` <= 1, go to HOLD.
  - Otherwise stay in FETCH; there is no timeout.
  - `pc_enable`, `halt` and `jump_en` are ignored in FETCH.
- **HOLD:** `imem_req`=0. The IR is stable and the control unit sequences the instruction.
  - `halt`=1 → STOP. `halt` has priority over a simultaneous `pc_enable`, and the PC is not changed.
  - Else if `pc_enable`=1: PC <= `jump_en` ? `jump_target` : PC+1, then `instr_valid` <= 0 and go to FETCH.
  - Otherwise hold.
- **STOP:** `imem_req`=0 and `instr_valid`=0. IR and PC are frozen, so `opcode` keeps its last value. Only reset leaves STOP.
- **PC arithmetic:** modulo 2^PC_WIDTH; 0xFF+1 wraps to 0x00. `jump_target` is loaded verbatim.
- **Stray acks:** `imem_ack` outside FETCH is ignored; IR is unchanged.
- **Reset values (asynchronous):** PC=0, `imem_addr`=0, IR=0 (so `opcode`/`rd`/`rs`/`rt`=0), `imem_req`=0, `instr_valid`=0, `fetch_state`=IDLE. Reset asserted mid-FETCH drops `imem_req` immediately, without waiting for a clock edge.

## Timing
- **Edge E0:** first rising edge with `reset`=1 moves IDLE→FETCH. `imem_req` goes high after E0 with `imem_addr`=0.
- **Fetch latency:** if `imem_ack` is high at edge E1, the IR loads at E1 and `instr_valid`=1 plus new `opcode` appear after E1. Minimum latency is 2 edges from reset release to a valid opcode. Each additional ack-wait cycle adds 1.
- **Back-to-back instructions:** `pc_enable` at edge Ek gives new `imem_addr` and `imem_req`=1 after Ek. The earliest next valid instruction is after Ek+1.
- **`instr_valid` low window:** `instr_valid` is low for at least 1 cycle between consecutive instructions. `opcode` keeps the old IR value until the new word loads.
- **`halt` latency:** `halt` seen at edge Eh gives `fetch_state`=STOP and `instr_valid`=0 after Eh.

## Test plan
- **Reset values:** hold `reset`=0 and toggle `imem_ack`/`pc_enable` → every output at its reset value. Assert `reset`=0 asynchronously mid-FETCH → `imem_req` falls before the next edge.
- **Single fetch, both ack latencies:** memory word 0x1A53 at address 0, ack latency 0 and then 3 cycles → `opcode`=0x1, `rd`=0xA, `rs`=0x5, `rt`=0x3, `instr_valid`=1 after 2 and 5 edges respectively.
- **Sequential stream:** memory holds opcodes 0x1, 0x3, 0x2 at addresses 0–2, with `pc_enable` pulsed once per instruction in HOLD → `imem_addr` sequence 0,1,2. `opcode` sequence 1,3,2, with `instr_valid` dropping between each.
- **Wrap and jump:**
  - PC=0xFF with `pc_enable` → `imem_addr`=0x00.
  - `jump_en`=1, `jump_target`=0x40 with `pc_enable` → `imem_addr`=0x40.
  - `jump_en`=1 without `pc_enable` → no change.
- **Halt priority:** fetch 0xF000, then assert `halt` and `pc_enable` in the same HOLD cycle → `fetch_state`=11, PC unchanged, `opcode`=0xF. Further `pc_enable`/`imem_ack` activity causes no change until reset.
- **Stray ack:** `imem_ack` pulsed with `imem_rdata`=0xBEEF during HOLD → IR unchanged.
